arb_mux_n: RTL and testbench
============================

ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 Parameter WIDTH, default 16, data width of every channel and of the output.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default 2, select/grant width; SHALL equal ceil(log2(N)).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 D  input  N*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 V  input  N  per-channel valid.
REQ-008 R  output  N  per-channel ready; at most one bit high per cycle.
REQ-009 S  input  SELW  static channel select, used in fixed mode only.
REQ-010 MODE  input  1  0 = fixed select by S, 1 = round-robin arbitration.
REQ-011 O  output  WIDTH  registered output data.
REQ-012 OV  output  1  output valid.
REQ-013 ORDY  input  1  downstream ready.
REQ-014 G  output  SELW  registered index of channel whose data is in O.

Function
REQ-015 Output stage SHALL be a single register (O, OV, G); accept = !OV || ORDY.
REQ-016 Transfer from channel k SHALL occur in a cycle where accept, V[k] and R[k] are all high; R is combinational from V, S, MODE, pointer P, OV, ORDY.
REQ-017 Fixed mode: R[S] = accept && V[S]; all other R bits 0; if S >= N, all R bits 0 and no transfer.
REQ-018 Round-robin mode: the granted channel SHALL be the first k with V[k] high, searching P, P+1, ... N-1, 0, ... P-1 (wrap modulo N).
REQ-019 Round-robin pointer P (SELW bits) SHALL update to (granted+1) mod N only on a transfer; on wrap from N-1, P = 0; P unchanged in fixed mode.
REQ-020 On a transfer, at the next edge O = D[k], G = k, OV = 1; latency one cycle from V&&R to OV.
REQ-021 If OV && ORDY and no transfer, OV SHALL clear next edge; O and G hold their values.
REQ-022 If OV && !ORDY, O, G, OV SHALL hold stable and all R bits SHALL be 0.
REQ-023 Simultaneous drain and fill (OV && ORDY && transfer): OV stays 1, O/G load new data, no bubble.
REQ-024 No V bit high (or selected V low in fixed mode): no transfer, R = 0, P unchanged.
REQ-025 MODE or S change SHALL not disturb a held output; takes effect on the next accept cycle.
REQ-026 A channel whose V drops without R high SHALL not be transferred; no request latching.

Reset
REQ-027 While RST high: OV = 0, O = 0, G = 0, P = 0, R = 0, regardless of CLK.
REQ-028 RST asserted mid-transfer (OV = 1, ORDY = 0) SHALL discard held data immediately; first accept after release starts round-robin search at channel 0.

Verification
REQ-029 Fixed mode, S=2, V=4'b0100, D2=16'hBEEF, ORDY=1 -> R=4'b0100 same cycle; next cycle O=16'hBEEF, OV=1, G=2.
REQ-030 RR mode, V=4'b1111 held, ORDY=1 from reset -> G sequence 0,1,2,3,0 on consecutive cycles, OV continuously 1.
REQ-031 RR mode, P=3, V=4'b0011 -> grant channel 0 (wrap), then P=1, next grant channel 1.
REQ-032 Backpressure: OV=1, O=16'h1234, ORDY=0 for 5 cycles with V=4'b1111 -> O stays 16'h1234, R=0 throughout; ORDY=1 -> next channel loaded next edge.
REQ-033 Fixed mode, N=3, S=3, V=3'b111 -> R=0, OV stays 0.
REQ-034 RST pulsed asynchronously between edges with OV=1 -> OV, O, G drop to 0 before next edge; after release V=4'b1000 -> G=3, then P=0.

Source files
------------

// File: rtl/arb_mux_n.sv
// N-channel valid/ready multiplexer with a single-register output stage.
// Channel choice is either a static select or round-robin arbitration.
module arb_mux_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N*WIDTH-1:0]   D,
    input  logic [N-1:0]         V,
    output logic [N-1:0]         R,
    input  logic [SELW-1:0]      S,
    input  logic                 MODE,
    output logic [WIDTH-1:0]     O,
    output logic                 OV,
    input  logic                 ORDY,
    output logic [SELW-1:0]      G
);

    logic [WIDTH-1:0] o_q,  o_d;
    logic             ov_q, ov_d;
    logic [SELW-1:0]  g_q,  g_d;
    logic [SELW-1:0]  p_q,  p_d;

    logic             accept_c;
    logic             rr_found_c;
    logic [SELW-1:0]  rr_idx_c;
    logic [SELW-1:0]  scan_idx_c;
    logic [SELW-1:0]  grant_c;
    logic [N-1:0]     r_c;
    logic [WIDTH-1:0] data_c;
    logic             xfer_c;

    // Ready generation: accept gating plus fixed-select or rotating-priority search.
    always_comb begin
        accept_c   = !RST && (!ov_q || ORDY);
        rr_found_c = 1'b0;
        rr_idx_c   = '0;
        scan_idx_c = '0;
        r_c        = '0;

        for (int unsigned i = 0; i < N; i++) begin
            scan_idx_c = SELW'((32'(p_q) + i) % N);
            if (!rr_found_c && V[scan_idx_c]) begin
                rr_found_c = 1'b1;
                rr_idx_c   = scan_idx_c;
            end
        end

        if (accept_c) begin
            if (MODE) begin
                if (rr_found_c) begin
                    r_c[rr_idx_c] = 1'b1;
                end
            end else if (32'(S) < N) begin
                if (V[S]) begin
                    r_c[S] = 1'b1;
                end
            end
        end

        grant_c = MODE ? rr_idx_c : S;
        xfer_c  = |r_c;
    end

    // One-hot ready doubles as the data select.
    always_comb begin
        data_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (r_c[k]) begin
                data_c = D[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        o_d  = o_q;
        ov_d = ov_q;
        g_d  = g_q;
        p_d  = p_q;
        if (xfer_c) begin
            o_d  = data_c;
            g_d  = grant_c;
            ov_d = 1'b1;
            if (MODE) begin
                p_d = (32'(grant_c) + 32'd1 == N) ? '0 : grant_c + SELW'(1);
            end
        end else if (ORDY) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_q  <= '0;
            ov_q <= 1'b0;
            g_q  <= '0;
            p_q  <= '0;
        end else begin
            o_q  <= o_d;
            ov_q <= ov_d;
            g_q  <= g_d;
            p_q  <= p_d;
        end
    end

    assign R  = r_c;
    assign O  = o_q;
    assign OV = ov_q;
    assign G  = g_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: directed scenarios and randomized traffic against a
// transaction-level reference model; a second N=3 instance covers out-of-range select.
module tb_arb_mux_n;

    logic        CLK;
    logic        RST;
    logic [63:0] D;
    logic [3:0]  V;
    logic [3:0]  R;
    logic [1:0]  S;
    logic        MODE;
    logic [15:0] O;
    logic        OV;
    logic        ORDY;
    logic [1:0]  G;

    logic [47:0] D3;
    logic [2:0]  V3;
    logic [2:0]  R3;
    logic [1:0]  S3;
    logic        MODE3;
    logic [15:0] O3;
    logic        OV3;
    logic        ORDY3;
    logic [1:0]  G3;

    int checks = 0;
    int errors = 0;

    // Reference state: output register contents and round-robin pointer.
    logic        m_ov;
    logic [15:0] m_o;
    int          m_g;
    int          m_p;

    arb_mux_n #(.WIDTH(16), .N(4), .SELW(2)) dut (
        .CLK(CLK), .RST(RST), .D(D), .V(V), .R(R), .S(S), .MODE(MODE),
        .O(O), .OV(OV), .ORDY(ORDY), .G(G)
    );

    arb_mux_n #(.WIDTH(16), .N(3), .SELW(2)) dut3 (
        .CLK(CLK), .RST(RST), .D(D3), .V(V3), .R(R3), .S(S3), .MODE(MODE3),
        .O(O3), .OV(OV3), .ORDY(ORDY3), .G(G3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Expected ready vector from the rules: nothing when blocked, else chosen channel.
    function automatic logic [3:0] exp_r();
        logic [3:0] r;
        r = '0;
        if (RST || (m_ov && !ORDY)) return r;
        if (!MODE) begin
            if (int'(S) < 4 && V[S]) r[S] = 1'b1;
        end else begin
            for (int off = 0; off < 4; off++) begin
                int k;
                k = (m_p + off) % 4;
                if (V[k]) begin
                    r[k] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ov = 1'b0;
        m_o  = '0;
        m_g  = 0;
        m_p  = 0;
    endtask

    // One clock: check ready mid-cycle, advance model at the edge, check outputs after.
    task automatic cycle(input string tag);
        logic [3:0] er;
        #1;
        er = exp_r();
        chk({tag, ".R"}, 32'(R), 32'(er));
        @(posedge CLK);
        if (er != 0) begin
            for (int k = 0; k < 4; k++) begin
                if (er[k]) begin
                    m_o  = D[k*16 +: 16];
                    m_g  = k;
                    m_ov = 1'b1;
                    if (MODE) m_p = (k + 1) % 4;
                end
            end
        end else if (ORDY) begin
            m_ov = 1'b0;
        end
        #1;
        chk({tag, ".OV"}, 32'(OV), 32'(m_ov));
        chk({tag, ".O"},  32'(O),  32'(m_o));
        chk({tag, ".G"},  32'(G),  32'(m_g));
    endtask

    initial begin
        RST = 1'b1; D = '0; V = '0; S = '0; MODE = 1'b0; ORDY = 1'b1;
        D3 = '0; V3 = '0; S3 = '0; MODE3 = 1'b0; ORDY3 = 1'b1;
        model_reset();

        // Reset state with live requests present
        V = 4'b1111;
        @(posedge CLK); #1;
        chk("rst.OV", 32'(OV), 32'd0);
        chk("rst.O",  32'(O),  32'd0);
        chk("rst.G",  32'(G),  32'd0);
        chk("rst.R",  32'(R),  32'd0);
        chk("rst.R3", 32'(R3), 32'd0);
        RST = 1'b0; V = '0;

        // Fixed select of channel 2
        MODE = 1'b0; S = 2'd2; V = 4'b0100; D = '0; D[47:32] = 16'hBEEF; ORDY = 1'b1;
        cycle("fix");
        chk("fix.Oval", 32'(O), 32'hBEEF);
        chk("fix.Gval", 32'(G), 32'd2);
        V = '0;
        cycle("fix_drain");

        // Round-robin from reset with all requesting
        RST = 1'b1; #1; RST = 1'b0; model_reset();
        MODE = 1'b1; V = 4'b1111; ORDY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            D = {$urandom(), $urandom()};
            cycle("rr4");
            chk("rr4.Gseq", 32'(G), 32'(i % 4));
            chk("rr4.OVon", 32'(OV), 32'd1);
        end
        // Pointer now 1; two more grants leave it at 3, then wrap to channel 0
        cycle("rr_p2");
        cycle("rr_p3");
        chk("rr_p3.G", 32'(G), 32'd2);
        V = 4'b0011;
        cycle("rr_wrap0");
        chk("rr_wrap0.G", 32'(G), 32'd0);
        cycle("rr_wrap1");
        chk("rr_wrap1.G", 32'(G), 32'd1);

        // Backpressure with a held word
        MODE = 1'b0; S = 2'd0; V = 4'b0001; D[15:0] = 16'h1234;
        cycle("bp_load");
        MODE = 1'b1; V = 4'b1111; ORDY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            D = {$urandom(), $urandom()};
            S = 2'($urandom_range(0, 3));
            cycle("bp_hold");
            chk("bp_hold.O", 32'(O), 32'h1234);
        end
        ORDY = 1'b1;
        cycle("bp_release");

        // N=3 instance: select beyond range, then a legal select
        MODE3 = 1'b0; S3 = 2'd3; V3 = 3'b111; D3 = {16'hCAFE, 16'h2222, 16'h1111};
        #1;
        chk("n3_oob.R", 32'(R3), 32'd0);
        V = '0;
        cycle("n3_side");
        chk("n3_oob.OV", 32'(OV3), 32'd0);
        S3 = 2'd2;
        #1;
        chk("n3_s2.R", 32'(R3), 32'b100);
        cycle("n3_side2");
        chk("n3_s2.O",  32'(O3),  32'hCAFE);
        chk("n3_s2.G",  32'(G3),  32'd2);
        chk("n3_s2.OV", 32'(OV3), 32'd1);
        V3 = '0;

        // Asynchronous reset between edges while holding data
        MODE = 1'b1; V = 4'b0100; ORDY = 1'b1; D = {$urandom(), $urandom()};
        cycle("ar_load");
        ORDY = 1'b0; V = 4'b1111;
        #1; RST = 1'b1; #1;
        chk("ar.OV", 32'(OV), 32'd0);
        chk("ar.O",  32'(O),  32'd0);
        chk("ar.G",  32'(G),  32'd0);
        chk("ar.R",  32'(R),  32'd0);
        #1; RST = 1'b0; model_reset();
        ORDY = 1'b1; V = 4'b1000;
        cycle("ar_g3");
        chk("ar_g3.G", 32'(G), 32'd3);
        V = 4'b1111;
        cycle("ar_p0");
        chk("ar_p0.G", 32'(G), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                MODE = 1'($urandom_range(0, 1));
                S    = 2'($urandom_range(0, 3));
                V    = 4'($urandom());
                D    = {$urandom(), $urandom()};
            end
            ORDY = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
